// File: rtl/deadtime_gen.sv
// Per-channel half-bridge dead-time generator; optional sticky fault latch under DEADTIME_FAULT_LATCH_EN.
// Latency: command to gate output is 3+dt_cycles edges after the first synchroniser captures it.
// Backpressure: none; inputs are free-running levels and outputs are registered gate drives.
module deadtime_gen #(
    parameter int NCH   = 3,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   high_in,
    input  logic [NCH-1:0]   low_in,
    input  logic [CNT_W-1:0] dt_cycles,
    input  logic             fault_clr,
    output logic [NCH-1:0]   high_out,
    output logic [NCH-1:0]   low_out,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   fault
);

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic             h_s1, h_s2, l_s1, l_s2;
        logic             diff, overlap, kill;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             hout_q, lout_q, hout_d, lout_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                h_s1 <= 1'b0;
                h_s2 <= 1'b0;
                l_s1 <= 1'b0;
                l_s2 <= 1'b0;
            end else begin
                h_s1 <= high_in[ch];
                h_s2 <= h_s1;
                l_s1 <= low_in[ch];
                l_s2 <= l_s1;
            end
        end

        // Any edge on either command, including both at once, starts one dead period.
        assign diff    = (h_s1 ^ h_s2) | (l_s1 ^ l_s2);
        assign overlap = h_s2 & l_s2;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hout_d  = 1'b0;
            lout_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (diff) begin
                        state_d = DEAD;
                        cnt_d   = dt_cycles;
                    end else if (!overlap) begin
                        hout_d = h_s2;
                        lout_d = l_s2;
                    end
                end
                DEAD: begin
                    if (diff) begin
                        cnt_d = dt_cycles;
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hout_q  <= 1'b0;
                lout_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hout_q  <= hout_d & ~kill;
                lout_q  <= lout_d & ~kill;
            end
        end

`ifdef DEADTIME_FAULT_LATCH_EN
        logic fault_q, fault_d;

        // Set dominates clear so a clear held during overlap cannot drop the flag.
        assign fault_d = overlap | (fault_q & ~fault_clr);
        assign kill    = fault_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) fault_q <= 1'b0;
            else        fault_q <= fault_d;
        end

        assign fault[ch] = fault_q;
`else
        assign kill      = 1'b0;
        assign fault[ch] = 1'b0;
`endif

        assign high_out[ch] = hout_q;
        assign low_out[ch]  = lout_q;
        assign busy[ch]     = (state_q == DEAD);
    end

`ifndef DEADTIME_FAULT_LATCH_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

endmodule

// File: tb/tb_deadtime_gen.sv
// Directed bench for deadtime_gen: expected per-edge output vectors are queued with each stimulus step.
module tb_deadtime_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 5;
`ifdef DEADTIME_FAULT_LATCH_EN
    localparam logic FLT = 1'b1;
`else
    localparam logic FLT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   high_in, low_in;
    logic [CNT_W-1:0] dt_cycles;
    logic             fault_clr;
    logic [NCH-1:0]   high_out, low_out, busy, fault;

    typedef struct packed {
        logic [NCH-1:0] ho;
        logic [NCH-1:0] lo;
        logic [NCH-1:0] bz;
        logic [NCH-1:0] ft;
    } exp_t;

    exp_t  exp_q[$];
    string tag;
    int    checks   = 0;
    int    failures = 0;

    deadtime_gen #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .high_in   (high_in),
        .low_in    (low_in),
        .dt_cycles (dt_cycles),
        .fault_clr (fault_clr),
        .high_out  (high_out),
        .low_out   (low_out),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [NCH-1:0] ho, input logic [NCH-1:0] lo,
                        input logic [NCH-1:0] bz, input logic [NCH-1:0] ft);
        exp_t e;
        e.ho = ho;
        e.lo = lo;
        e.bz = bz;
        e.ft = ft;
        exp_q.push_back(e);
    endtask

    task automatic cmp1(input string name, input logic [NCH-1:0] obs, input logic [NCH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, name, obs, expv);
        end
    endtask

    task automatic check_now();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp1("high_out", high_out, e.ho);
            cmp1("low_out",  low_out,  e.lo);
            cmp1("busy",     busy,     e.bz);
            cmp1("fault",    fault,    e.ft);
        end
    endtask

    // One queued entry per clock edge, sampled 1 time unit after the edge.
    task automatic drain();
        int n;
        n = exp_q.size();
        repeat (n) begin
            @(posedge clk);
            #1;
            check_now();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        high_in   = 3'($urandom_range(0, 7));
        low_in    = 3'($urandom_range(0, 7));
        dt_cycles = 5'($urandom_range(0, 31));
        fault_clr = 1'b0;

        tag = "reset_held";
        repeat (3) push(3'b000, 3'b000, 3'b000, 3'b000);
        drain();

        tag = "reset_release";
        high_in = '0;
        low_in  = '0;
        rst_n   = 1'b1;
        repeat (4) push(3'b000, 3'b000, 3'b000, 3'b000);
        drain();

        tag = "ch0_rise_d5";
        dt_cycles   = 5'd5;
        high_in[0]  = 1'b1;
        for (int e = 0; e <= 8; e++)
            push((e >= 8) ? 3'b001 : 3'b000, 3'b000,
                 (e >= 1 && e <= 6) ? 3'b001 : 3'b000, 3'b000);
        drain();

        tag = "ch1_rise_d0";
        dt_cycles  = 5'd0;
        high_in[1] = 1'b1;
        for (int e = 0; e <= 3; e++)
            push((e >= 3) ? 3'b011 : 3'b001, 3'b000,
                 (e == 1) ? 3'b010 : 3'b000, 3'b000);
        drain();

        tag = "ch1_swap_d31";
        dt_cycles  = 5'd31;
        high_in[1] = 1'b0;
        low_in[1]  = 1'b1;
        for (int e = 0; e <= 35; e++)
            push((e == 0) ? 3'b011 : 3'b001, (e >= 34) ? 3'b010 : 3'b000,
                 (e >= 1 && e <= 32) ? 3'b010 : 3'b000, 3'b000);
        drain();

        tag = "ch2_retrig_load";
        dt_cycles = 5'd10;
        low_in[2] = 1'b1;
        for (int e = 0; e <= 7; e++)
            push(3'b001, 3'b010, (e >= 1) ? 3'b100 : 3'b000, 3'b000);
        drain();

        tag = "ch2_retrig_hit";
        low_in[2] = 1'b0;
        for (int e = 8; e <= 9; e++)
            push(3'b001, 3'b010, 3'b100, 3'b000);
        drain();

        tag = "ch2_retrig_tail";
        dt_cycles = 5'd2;
        for (int e = 10; e <= 21; e++)
            push(3'b001, 3'b010, (e <= 19) ? 3'b100 : 3'b000, 3'b000);
        drain();

        tag = "ch0_overlap";
        dt_cycles = 5'd2;
        low_in[0] = 1'b1;
        for (int e = 0; e <= 6; e++)
            push((e == 0) ? 3'b001 : 3'b000, 3'b010,
                 (e >= 1 && e <= 3) ? 3'b001 : 3'b000,
                 (e >= 2) ? {2'b00, FLT} : 3'b000);
        drain();

        tag = "ch0_fault_sticky";
        high_in[0] = 1'b0;
        low_in[0]  = 1'b0;
        for (int e = 0; e <= 5; e++)
            push(3'b000, 3'b010, (e >= 1 && e <= 3) ? 3'b001 : 3'b000, {2'b00, FLT});
        drain();

        tag = "ch0_fault_clr";
        fault_clr = 1'b1;
        push(3'b000, 3'b010, 3'b000, 3'b000);
        drain();
        fault_clr = 1'b0;

        tag = "ch0_clr_during_overlap";
        fault_clr  = 1'b1;
        high_in[0] = 1'b1;
        low_in[0]  = 1'b1;
        for (int e = 0; e <= 6; e++)
            push(3'b000, 3'b010, (e >= 1 && e <= 3) ? 3'b001 : 3'b000,
                 (e >= 2) ? {2'b00, FLT} : 3'b000);
        drain();

        tag = "ch0_clr_after_overlap";
        high_in[0] = 1'b0;
        low_in[0]  = 1'b0;
        for (int e = 0; e <= 5; e++)
            push(3'b000, 3'b010, (e >= 1 && e <= 3) ? 3'b001 : 3'b000,
                 (e <= 1) ? {2'b00, FLT} : 3'b000);
        drain();
        fault_clr = 1'b0;

        tag = "ch1_pre_reset";
        dt_cycles  = 5'd6;
        high_in[1] = 1'b1;
        low_in[1]  = 1'b0;
        for (int e = 0; e <= 2; e++)
            push(3'b000, (e == 0) ? 3'b010 : 3'b000, (e >= 1) ? 3'b010 : 3'b000, 3'b000);
        drain();

        tag = "ch1_async_reset";
        rst_n = 1'b0;
        #1;
        push(3'b000, 3'b000, 3'b000, 3'b000);
        check_now();
        repeat (2) push(3'b000, 3'b000, 3'b000, 3'b000);
        drain();

        tag = "ch1_after_reset";
        rst_n = 1'b1;
        for (int e = 0; e <= 9; e++)
            push((e >= 9) ? 3'b010 : 3'b000, 3'b000,
                 (e >= 1 && e <= 7) ? 3'b010 : 3'b000, 3'b000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
